// File: rtl/interval_result_reader.sv
// interval_result_reader: captures each completed min/max interval from the
// tracker, derives peak-to-peak amplitude and queues results in a small
// first-word-fall-through FIFO with saturating drop accounting.
module interval_result_reader #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AW     = 2,
    parameter int unsigned DROP_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mm_ready,
    input  logic signed [15:0] mm_min,
    input  logic signed [15:0] mm_max,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_min,
    output logic signed [15:0] out_max,
    output logic [16:0]        out_p2p,
    output logic               out_no_samples,
    output logic [AW:0]        fifo_count,
    output logic [DROP_W-1:0]  drop_count,
    input  logic               clear_drops
);

    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic signed [15:0] min_v;
        logic signed [15:0] max_v;
        logic [16:0]        p2p;
        logic               no_samples;
    } entry_t;

    entry_t              mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count_q;
    logic                valid_q;
    logic                ready_d;
    logic [DROP_W-1:0]   drops_q;

    logic                capture_c;
    logic                full_c;
    logic                pop_c;
    logic                push_c;
    logic                drop_c;
    logic signed [16:0]  diff_c;
    entry_t              entry_c;
    logic [AW:0]         count_next_c;

    // Capture detection, entry derivation and FIFO push/pop/drop decisions
    always_comb begin
        capture_c    = mm_ready & ~ready_d;
        full_c       = (count_q == CW'(DEPTH));
        pop_c        = valid_q & out_ready;
        push_c       = capture_c & (~full_c | pop_c);
        drop_c       = capture_c & full_c & ~pop_c;
        diff_c       = 17'({mm_max[15], mm_max}) - 17'({mm_min[15], mm_min});
        entry_c            = '0;
        entry_c.min_v      = mm_min;
        entry_c.max_v      = mm_max;
        entry_c.no_samples = (mm_min > mm_max);
        entry_c.p2p        = entry_c.no_samples ? 17'd0 : 17'(diff_c);
        count_next_c = count_q + CW'(push_c) - CW'(pop_c);
    end

    // Edge detector, FIFO pointers, occupancy and head-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_d <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            ready_d <= mm_ready;
            if (push_c) begin
                wr_ptr <= AW'(wr_ptr + 1'b1);
            end
            if (pop_c) begin
                rd_ptr <= AW'(rd_ptr + 1'b1);
            end
            count_q <= count_next_c;
            valid_q <= (count_next_c != '0);
        end
    end

    // Saturating drop counter; a drop in the clearing cycle leaves a count of one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drops_q <= '0;
        end else if (drop_c) begin
            if (clear_drops) begin
                drops_q <= DROP_W'(1);
            end else if (drops_q != '1) begin
                drops_q <= drops_q + 1'b1;
            end
        end else if (clear_drops) begin
            drops_q <= '0;
        end
    end

    // Entry storage; contents need no reset since reads are gated by valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= entry_c;
        end
    end

    // Head fields come straight from storage and read zero when empty
    always_comb begin
        out_valid      = valid_q;
        out_min        = valid_q ? mem[rd_ptr].min_v      : 16'sd0;
        out_max        = valid_q ? mem[rd_ptr].max_v      : 16'sd0;
        out_p2p        = valid_q ? mem[rd_ptr].p2p        : 17'd0;
        out_no_samples = valid_q ? mem[rd_ptr].no_samples : 1'b0;
        fifo_count     = count_q;
        drop_count     = drops_q;
    end

endmodule

// File: tb/tb_interval_result_reader.sv
// Bench for interval_result_reader: directed scenarios plus random traffic,
// checked by a scoreboard queue against an abstract reference model.
module tb_interval_result_reader;

    localparam int DEPTH  = 4;
    localparam int AW     = 2;
    localparam int DROP_W = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               mm_ready = 1'b0;
    logic signed [15:0] mm_min = 16'sd0;
    logic signed [15:0] mm_max = 16'sd0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_min;
    logic signed [15:0] out_max;
    logic [16:0]        out_p2p;
    logic               out_no_samples;
    logic [AW:0]        fifo_count;
    logic [DROP_W-1:0]  drop_count;
    logic               clear_drops = 1'b0;

    interval_result_reader #(.DEPTH(DEPTH), .AW(AW), .DROP_W(DROP_W)) dut (
        .clk(clk), .rst_n(rst_n), .mm_ready(mm_ready), .mm_min(mm_min),
        .mm_max(mm_max), .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_max(out_max), .out_p2p(out_p2p),
        .out_no_samples(out_no_samples), .fifo_count(fifo_count),
        .drop_count(drop_count), .clear_drops(clear_drops)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mn;
        int mx;
        int p2p;
        int ns;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_drops  = 0;
    bit   m_prev   = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result of an interval, straight from the arithmetic definition
    function automatic exp_t mk(input int mn, input int mx);
        exp_t e;
        e.mn  = mn;
        e.mx  = mx;
        e.ns  = (mn > mx) ? 1 : 0;
        e.p2p = (mn > mx) ? 0 : (mx - mn);
        return e;
    endfunction

    // Monitor: compare DUT state against the model on every falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("count", 32'(fifo_count), 32'(sb.size()));
            chk("drops", 32'(drop_count), 32'(m_drops));
            if (sb.size() != 0) begin
                chk("min", 32'($signed(out_min)), 32'(sb[0].mn));
                chk("max", 32'($signed(out_max)), 32'(sb[0].mx));
                chk("p2p", 32'(out_p2p), 32'(sb[0].p2p));
                chk("nosamp", 32'(out_no_samples), 32'(sb[0].ns));
                if (out_ready) void'(sb.pop_front());
            end else begin
                chk("empty_data", 32'({out_min, out_no_samples}), 32'd0);
                chk("empty_data2", 32'({out_max, out_p2p[14:0]}), 32'd0);
            end
        end
    end

    // Model of what the coming rising edge does, evaluated after the monitor's pop
    task automatic model();
        bit cap;
        bit drop;
        if (!rst_n) begin
            m_prev = 1'b1;
            return;
        end
        cap    = mm_ready && !m_prev;
        m_prev = mm_ready;
        drop   = 1'b0;
        if (cap) begin
            if (sb.size() < DEPTH) sb.push_back(mk(int'(mm_min), int'(mm_max)));
            else drop = 1'b1;
        end
        if (drop) m_drops = clear_drops ? 1 : ((m_drops < DROP_MAX) ? m_drops + 1 : DROP_MAX);
        else if (clear_drops) m_drops = 0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        model();
        @(posedge clk);
        #1;
    endtask

    // One-cycle interval strobe; the tracker returns to idle values afterwards
    task automatic pulse(input int mn, input int mx);
        mm_min   = 16'(mn);
        mm_max   = 16'(mx);
        mm_ready = 1'b1;
        step();
        mm_ready = 1'b0;
        mm_min   = 16'sh7FFF;
        mm_max   = 16'sh8000;
        step();
    endtask

    initial begin
        int guard;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        chk("rst_data", 32'({out_min, out_no_samples}), 32'd0);
        chk("rst_p2p", 32'(out_p2p), 32'd0);
        rst_n = 1'b1;
        step();

        // Single capture, full scale, empty interval
        out_ready = 1'b1;
        pulse(-300, 1200);
        step();
        pulse(-32768, 32767);
        pulse(32767, -32768);
        step();

        // Stall and overflow, then drain and clear
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse(i * 100 - 250, i * 137 + 7);
        chk("ovf_count", 32'(fifo_count), 32'd4);
        chk("ovf_drops", 32'(drop_count), 32'd2);
        out_ready = 1'b1;
        repeat (6) step();
        clear_drops = 1'b1;
        step();
        clear_drops = 1'b0;
        step();
        chk("cleared", 32'(drop_count), 32'd0);

        // Full with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(-10 * i, 20 * i + 5);
        mm_min = -16'sd77; mm_max = 16'sd999; mm_ready = 1'b1; out_ready = 1'b1;
        step();
        mm_ready = 1'b0; out_ready = 1'b0;
        step();
        chk("pp_count", 32'(fifo_count), 32'd4);
        chk("pp_drops", 32'(drop_count), 32'd0);
        out_ready = 1'b1;
        repeat (6) step();

        // Drop coinciding with clear leaves a count of one
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(i, 3 * i);
        mm_min = 16'sd1; mm_max = 16'sd2; mm_ready = 1'b1; clear_drops = 1'b1;
        step();
        mm_ready = 1'b0; clear_drops = 1'b0;
        step();
        chk("clr_drop", 32'(drop_count), 32'd1);

        // Saturation of the drop counter
        for (int i = 0; i < 260; i++) pulse(i, i + 1);
        chk("sat", 32'(drop_count), 32'(DROP_MAX));
        out_ready = 1'b1;
        repeat (6) step();

        // Long pulse yields one entry; reset mid-stream clears everything
        out_ready = 1'b0;
        mm_min = -16'sd5; mm_max = 16'sd5; mm_ready = 1'b1;
        repeat (5) step();
        mm_ready = 1'b0;
        step();
        chk("long_count", 32'(fifo_count), 32'd1);
        pulse(100, 200);
        pulse(-400, -300);
        mm_ready = 1'b1;
        rst_n = 1'b0;
        sb.delete();
        m_drops = 0;
        m_prev  = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_drops", 32'(drop_count), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("no_cap_after_rst", 32'(fifo_count), 32'd0);
        mm_ready = 1'b0;
        step();
        pulse(11, 22);
        out_ready = 1'b1;
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            mm_ready    = ($urandom_range(0, 2) == 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            clear_drops = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) begin
                mm_min = 16'sh7FFF; mm_max = 16'sh8000;
            end else begin
                mm_min = 16'($urandom); mm_max = 16'($urandom);
            end
            step();
        end

        // Bounded drain
        mm_ready = 1'b0; clear_drops = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            step();
            guard++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/interval_result_reader.md
Name: interval_result_reader

Overview:
- Downstream consumer of the interval min/max tracker.
- Detects each completed interval on the tracker's ready strobe and captures the signed min/max pair.
- Derives the peak-to-peak amplitude and queues results in a small FIFO.
- Presents results on a valid/ready stream to the reporting/packetiser stage, with drop accounting when the consumer stalls.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, pointer width = log2(DEPTH).
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mm_ready  input  1  tracker interval-complete strobe; min/max are valid in every cycle it is high.
- mm_min  input  16  signed interval minimum from the tracker.
- mm_max  input  16  signed interval maximum from the tracker.
- out_valid  output  1  head result available.
- out_ready  input  1  downstream accepts head result.
- out_min  output  16  signed head minimum.
- out_max  output  16  signed head maximum.
- out_p2p  output  17  unsigned peak-to-peak (max - min).
- out_no_samples  output  1  head interval contained no samples.
- fifo_count  output  AW+1  entries held.
- drop_count  output  DROP_W  results lost to a full FIFO; saturates at all-ones.
- clear_drops  input  1  synchronous clear of drop_count.

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_count=0, out_valid=0, and out_min, out_max, out_p2p, out_no_samples all 0. drop_count=0. The edge-detect register ready_d is set to 1, so a mm_ready already high at reset release does not capture. Reset mid-operation discards all queued entries.
- Capture event:
  - Occurs in a cycle where mm_ready=1 and ready_d=0. ready_d <= mm_ready every cycle.
  - Exactly one capture per high pulse, regardless of its length.
  - mm_min and mm_max are sampled in the capture cycle itself; the tracker clears them on the following cycle.
- Derivation, done combinationally at capture and stored with the entry:
  - no_samples = (mm_min > mm_max), signed compare. True for the tracker's idle values 0x7FFF/0x8000.
  - If no_samples: p2p = 0.
  - Otherwise: p2p = sign-extend-17(mm_max) - sign-extend-17(mm_min). Range 0..65535 (0x0FFFF); never negative.
- FIFO:
  - First-word-fall-through. Head fields drive the out_* ports directly from storage.
  - Latency: capture at edge N -> out_valid=1 after edge N, if the FIFO was empty.
  - Pop occurs when out_valid & out_ready.
  - out_* are held stable while out_valid & !out_ready.
  - When empty, out_* data ports read 0.
- Boundary cases:
  - Push while full without a pop: entry is discarded and drop_count increments (saturating). FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both accepted, count unchanged, no drop.
  - Push and pop in the same cycle while not empty: count unchanged.
  - Pop while empty: ignored.
  - clear_drops together with a drop: drop_count=1.
  - clear_drops without a drop: drop_count=0 on the next edge.
  - Pointers wrap modulo DEPTH. Full is indicated by fifo_count==DEPTH.
- No state machine beyond the edge detector and the FIFO pointers. All outputs are registered or are direct FIFO reads; there are no combinational paths from out_ready to out_valid.

Test Plan:
- Single capture: mm_min=-300 and mm_max=1200, held while a one-cycle mm_ready pulse is applied, out_ready=1 -> next cycle out_valid=1, out_min=-300, out_max=1200, out_p2p=1500, out_no_samples=0. The entry pops the following cycle.
- Full-scale: mm_min=0x8000, mm_max=0x7FFF, one pulse -> out_p2p=0x0FFFF, no overflow.
- Empty interval: mm_min=0x7FFF, mm_max=0x8000, one pulse -> out_no_samples=1, out_p2p=0.
- Stall and overflow (DEPTH=4):
  - out_ready=0; six pulses with distinct values -> fifo_count=4, drop_count=2.
  - Then out_ready=1 -> the first four captured values emerge in order, then out_valid=0.
  - Then clear_drops -> drop_count=0.
- Full with simultaneous push/pop: FIFO holds 4 entries; a capture and out_ready=1 in the same cycle -> fifo_count stays 4, drop_count unchanged, and the new entry appears as the 4th output.
- Long pulse and reset:
  - mm_ready held high for 5 cycles -> exactly one entry.
  - Assert rst_n=0 mid-stream with 3 entries queued -> out_valid=0, fifo_count=0, drop_count=0 immediately.
  - Release reset with mm_ready still high -> no capture until mm_ready goes low, then high again.
